// File: rtl/vga_regs_pkg.sv
// Shared register-map offsets, bit positions and commit FSM encoding for the VGA frame register block.
// Latency: none (constants only); backpressure: not applicable.
package vga_regs_pkg;

  // Control/status word offsets, added to NUM_REGS to form the bus address
  localparam int CTRL_OFS   = 0;
  localparam int STATUS_OFS = 1;
  localparam int FCNT_OFS   = 2;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_AUTO = 1;

  localparam int ST_PEND = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } commit_state_t;

endpackage

// File: rtl/vga_frame_regs.sv
// Avalon-MM shadow/active register bank; the shadow bank is copied to the active bank atomically on frame_start.
// Latency: reads 1 cycle, commit visible the edge after frame_start; backpressure: none, the bus never stalls.
module vga_frame_regs
  import vga_regs_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic                       read,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          writedata,
  output logic [DATA_W-1:0]          readdata,
  input  logic                       frame_start,
  output logic [NUM_REGS*DATA_W-1:0] active_regs,
  output logic                       commit_pulse,
  output logic                       pending,
  output logic [15:0]                frame_count
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_REGS + CTRL_OFS);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_REGS + STATUS_OFS);
  localparam logic [ADDR_W-1:0] A_FCNT   = ADDR_W'(NUM_REGS + FCNT_OFS);

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];

  commit_state_t state_q;
  logic          auto_q;
  logic          done_q;
  logic          ovr_q;
  logic          commit_pulse_q;
  logic [15:0]   frame_count_q;
  logic [DATA_W-1:0] readdata_q;

  logic wr_en, rd_en, ctrl_wr, status_rd, arm_req, commit, ovr_set;
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    wr_en     = chipselect && write;
    rd_en     = chipselect && read;
    ctrl_wr   = wr_en && (address == A_CTRL);
    status_rd = rd_en && (address == A_STATUS);
    arm_req   = ctrl_wr && writedata[CTRL_ARM];
    // AUTO uses the value stored before any CTRL write in this same cycle
    commit    = frame_start && ((state_q == ARMED) || auto_q);
    ovr_set   = arm_req && (state_q == ARMED) && !frame_start;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_q[gi] <= '0;
        end else if (wr_en && (address == ADDR_W'(gi))) begin
          shadow_q[gi] <= writedata;
        end
      end

      // Reads the pre-write shadow value, so a coincident write waits for the next commit
      always_ff @(posedge clk) begin
        if (reset) begin
          active_q[gi] <= '0;
        end else if (commit) begin
          active_q[gi] <= shadow_q[gi];
        end
      end

      assign active_regs[gi*DATA_W +: DATA_W] = active_q[gi];
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address == ADDR_W'(i)) rd_mux = shadow_q[i];
    end
    if (address == A_CTRL) begin
      rd_mux[CTRL_AUTO] = auto_q;
    end else if (address == A_STATUS) begin
      rd_mux[ST_PEND] = (state_q == ARMED);
      rd_mux[ST_DONE] = done_q;
      rd_mux[ST_OVR]  = ovr_q;
    end else if (address == A_FCNT) begin
      rd_mux = DATA_W'(frame_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      auto_q         <= 1'b0;
      done_q         <= 1'b0;
      ovr_q          <= 1'b0;
      commit_pulse_q <= 1'b0;
      frame_count_q  <= '0;
      readdata_q     <= '0;
    end else begin
      commit_pulse_q <= commit;
      if (frame_start) frame_count_q <= frame_count_q + 16'd1;
      if (ctrl_wr) auto_q <= writedata[CTRL_AUTO];
      // A set in the same cycle as a STATUS read wins over the clear
      done_q <= commit  || (done_q && !status_rd);
      ovr_q  <= ovr_set || (ovr_q  && !status_rd);
      if (rd_en) readdata_q <= rd_mux;
      case (state_q)
        IDLE:    if (arm_req) state_q <= ARMED;
        ARMED:   if (frame_start && !arm_req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readdata     = readdata_q;
  assign commit_pulse = commit_pulse_q;
  assign pending      = (state_q == ARMED);
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_frame_regs.sv
// Scoreboarded bench for vga_frame_regs: directed scenarios plus random bus/frame traffic against a register-level model.
module tb_vga_frame_regs;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            chipselect = 1'b0;
  logic            write = 1'b0;
  logic            read = 1'b0;
  logic [AW-1:0]   address = '0;
  logic [DW-1:0]   writedata = '0;
  logic [DW-1:0]   readdata;
  logic            frame_start = 1'b0;
  logic [N*DW-1:0] active_regs;
  logic            commit_pulse;
  logic            pending;
  logic [15:0]     frame_count;

  always #5 clk = ~clk;

  vga_frame_regs #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .read         (read),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .frame_start  (frame_start),
    .active_regs  (active_regs),
    .commit_pulse (commit_pulse),
    .pending      (pending),
    .frame_count  (frame_count)
  );

  typedef struct {
    logic [DW-1:0]   rd;
    logic [N*DW-1:0] act;
    logic            cp;
    logic            pend;
    logic [15:0]     fc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: register map state as plain variables
  logic [DW-1:0] m_sh  [N];
  logic [DW-1:0] m_act [N];
  bit            m_armed, m_auto, m_done, m_ovr, m_cp;
  logic [15:0]   m_fc;
  logic [DW-1:0] m_rd;

  task automatic chk(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    if (a < 5'(N))            v = m_sh[a[3:0]];
    else if (a == 5'(N))      v[1] = m_auto;
    else if (a == 5'(N + 1))  v[2:0] = {m_ovr, m_done, m_armed};
    else if (a == 5'(N + 2))  v = m_fc;
    return v;
  endfunction

  task automatic step(input bit rst, input bit cs, input bit wr, input bit rd,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit fs);
    exp_t e;
    logic [DW-1:0] rv;
    bit commit, arm, st_rd;
    @(negedge clk);
    reset = rst; chipselect = cs; write = wr; read = rd;
    address = a; writedata = wd; frame_start = fs;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_sh[i] = '0; m_act[i] = '0; end
      m_armed = 0; m_auto = 0; m_done = 0; m_ovr = 0; m_cp = 0;
      m_fc = '0; m_rd = '0;
    end else begin
      rv     = model_read(a);
      commit = fs && (m_armed || m_auto);
      arm    = cs && wr && (a == 5'(N)) && wd[0];
      st_rd  = cs && rd && (a == 5'(N + 1));
      if (cs && rd) m_rd = rv;
      m_cp = commit;
      if (commit) for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
      if (cs && wr && a < 5'(N)) m_sh[a[3:0]] = wd;
      if (cs && wr && a == 5'(N)) m_auto = wd[1];
      if (st_rd) begin m_done = 0; m_ovr = 0; end
      if (commit) m_done = 1;
      if (arm && m_armed && !fs) m_ovr = 1;
      if (arm) m_armed = 1;
      else if (fs) m_armed = 0;
      if (fs) m_fc = m_fc + 16'd1;
    end
    e.rd = m_rd; e.cp = m_cp; e.pend = m_armed; e.fc = m_fc;
    for (int i = 0; i < N; i++) e.act[i*DW +: DW] = m_act[i];
    sbq.push_back(e);
  endtask

  task automatic idle();                                step(0, 0, 0, 0, '0, '0, 0); endtask
  task automatic wr_reg(input int a, input int d, input bit fs); step(0, 1, 1, 0, 5'(a), 16'(d), fs); endtask
  task automatic rd_reg(input int a);                   step(0, 1, 0, 1, 5'(a), '0, 0); endtask
  task automatic pulse();                               step(0, 0, 0, 0, '0, '0, 1); endtask
  task automatic do_reset();                            step(1, 0, 0, 0, '0, '0, 0); endtask

  // Monitor: every cycle after the edge, the DUT outputs are compared with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("readdata",     {{(N*DW-DW){1'b0}}, readdata},    {{(N*DW-DW){1'b0}}, e.rd});
        chk("active_regs",  active_regs,                      e.act);
        chk("commit_pulse", {{(N*DW-1){1'b0}}, commit_pulse}, {{(N*DW-1){1'b0}}, e.cp});
        chk("pending",      {{(N*DW-1){1'b0}}, pending},      {{(N*DW-1){1'b0}}, e.pend});
        chk("frame_count",  {{(N*DW-16){1'b0}}, frame_count}, {{(N*DW-16){1'b0}}, e.fc});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, shadow write not visible on the active side, readback
    do_reset(); do_reset();
    wr_reg(3, 16'h1234, 0);
    rd_reg(3);
    idle();

    // 2: armed commit, DONE sticky then cleared by read
    wr_reg(0, 16'hBEEF, 0);
    wr_reg(N, 1, 0);
    idle(); idle();
    pulse();
    idle(); idle();
    rd_reg(N + 1);
    rd_reg(N + 1);

    // 3: shadow write coincident with commit
    wr_reg(5, 16'h0011, 0);
    wr_reg(N, 1, 0);
    wr_reg(5, 16'h00AA, 1);
    idle();
    wr_reg(N, 1, 0);
    pulse();
    idle();

    // 4: AUTO mode commits every frame
    wr_reg(N, 2, 0);
    for (int k = 0; k < 3; k++) begin
      wr_reg(1, 16'h0100 + k, 0);
      idle();
      pulse();
      idle();
    end
    wr_reg(N, 0, 0);
    rd_reg(N + 1);

    // 5: double arm -> OVERRUN, then reset while armed
    wr_reg(N, 2, 0);
    wr_reg(N, 3, 0);
    wr_reg(N, 1, 0);
    rd_reg(N + 1);
    rd_reg(N);
    wr_reg(N, 1, 0);
    wr_reg(N, 1, 1);
    step(1, 0, 0, 0, '0, '0, 1);
    idle();
    rd_reg(N);
    // ARM coincident with frame_start while idle: no commit, becomes armed
    wr_reg(7, 16'h7777, 0);
    wr_reg(N, 1, 1);
    idle();
    pulse();
    idle();

    // 6: frame counter wrap
    do_reset();
    for (int k = 0; k < 65536; k++) pulse();
    rd_reg(N + 2);
    pulse();
    rd_reg(N + 2);
    idle();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      bit cs, wr, rd, fs, rst;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      rst = ($urandom_range(0, 399) == 0);
      cs  = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1) == 1;
      rd  = !wr && ($urandom_range(0, 1) == 1);
      a   = ($urandom_range(0, 2) == 0) ? 5'(N + $urandom_range(0, 2)) : 5'($urandom_range(0, 31));
      d   = 16'($urandom);
      fs  = ($urandom_range(0, 5) == 0);
      step(rst, cs, wr, rd, a, d, fs);
    end

    idle(); idle();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding predictions expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
